// File: rtl/hysteresis_wave_comparator.sv
// DDS-style waveform generator (sine/square/triangle/sawtooth) driving a
// Schmitt-trigger comparator that turns the sample stream into a clean 1-bit
// square wave.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_LOW  | comparator output low; waits for wave_out >= TH_HIGH
//   ST_HIGH | comparator output high; waits for wave_out <= TH_LOW
module hysteresis_wave_comparator #(
    parameter logic [7:0] TH_HIGH = 8'd192,
    parameter logic [7:0] TH_LOW  = 8'd64
) (
    input  logic       clk_100kHz,
    input  logic       rst_,
    input  logic [1:0] sw,
    input  logic [7:0] freq_ctrl,
    output logic [7:0] wave_out,
    output logic       square_wave
);

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } cmp_state_t;

    logic [7:0] phase;
    logic [7:0] sample_next;
    logic [5:0] q_idx;
    logic [6:0] q_mag;
    logic [7:0] sine_val;
    cmp_state_t cmp_state;
    cmp_state_t cmp_next;

    // round(127*sin(2*pi*i/256)) for i = 0..63; i = 64 (the peak) is handled outside
    function automatic logic [6:0] quarter_sine(input logic [5:0] idx);
        logic [6:0] v;
        case (idx)
            6'd0:  v = 7'd0;    6'd1:  v = 7'd3;    6'd2:  v = 7'd6;    6'd3:  v = 7'd9;
            6'd4:  v = 7'd12;   6'd5:  v = 7'd16;   6'd6:  v = 7'd19;   6'd7:  v = 7'd22;
            6'd8:  v = 7'd25;   6'd9:  v = 7'd28;   6'd10: v = 7'd31;   6'd11: v = 7'd34;
            6'd12: v = 7'd37;   6'd13: v = 7'd40;   6'd14: v = 7'd43;   6'd15: v = 7'd46;
            6'd16: v = 7'd49;   6'd17: v = 7'd51;   6'd18: v = 7'd54;   6'd19: v = 7'd57;
            6'd20: v = 7'd60;   6'd21: v = 7'd63;   6'd22: v = 7'd65;   6'd23: v = 7'd68;
            6'd24: v = 7'd71;   6'd25: v = 7'd73;   6'd26: v = 7'd76;   6'd27: v = 7'd78;
            6'd28: v = 7'd81;   6'd29: v = 7'd83;   6'd30: v = 7'd85;   6'd31: v = 7'd88;
            6'd32: v = 7'd90;   6'd33: v = 7'd92;   6'd34: v = 7'd94;   6'd35: v = 7'd96;
            6'd36: v = 7'd98;   6'd37: v = 7'd100;  6'd38: v = 7'd102;  6'd39: v = 7'd104;
            6'd40: v = 7'd106;  6'd41: v = 7'd107;  6'd42: v = 7'd109;  6'd43: v = 7'd111;
            6'd44: v = 7'd112;  6'd45: v = 7'd113;  6'd46: v = 7'd115;  6'd47: v = 7'd116;
            6'd48: v = 7'd117;  6'd49: v = 7'd118;  6'd50: v = 7'd120;  6'd51: v = 7'd121;
            6'd52: v = 7'd122;  6'd53: v = 7'd122;  6'd54: v = 7'd123;  6'd55: v = 7'd124;
            6'd56: v = 7'd125;  6'd57: v = 7'd125;  6'd58: v = 7'd126;  6'd59: v = 7'd126;
            6'd60: v = 7'd126;  6'd61: v = 7'd127;  6'd62: v = 7'd127;  6'd63: v = 7'd127;
            default: v = 7'd0;
        endcase
        return v;
    endfunction

    // Waveform sample for the current (pre-update) phase
    always_comb begin
        q_idx = phase[6] ? (6'd0 - phase[5:0]) : phase[5:0];
        q_mag = (phase[6] && (phase[5:0] == 6'd0)) ? 7'd127 : quarter_sine(q_idx);
        sine_val = phase[7] ? (8'd128 - {1'b0, q_mag}) : (8'd128 + {1'b0, q_mag});
        case (sw)
            2'b00:   sample_next = sine_val;
            2'b01:   sample_next = phase[7] ? 8'd0 : 8'd255;
            2'b10:   sample_next = {(phase[7] ? ~phase[6:0] : phase[6:0]), 1'b0};
            default: sample_next = phase;
        endcase
    end

    // Phase accumulator and registered sample
    always_ff @(posedge clk_100kHz or posedge rst_) begin
        if (rst_) begin
            phase    <= 8'd0;
            wave_out <= 8'd0;
        end else begin
            phase    <= phase + freq_ctrl;
            wave_out <= sample_next;
        end
    end

    // Comparator state register
    always_ff @(posedge clk_100kHz or posedge rst_) begin
        if (rst_) begin
            cmp_state <= ST_LOW;
        end else begin
            cmp_state <= cmp_next;
        end
    end

    // Hysteresis decision on the registered sample; between thresholds it holds
    always_comb begin
        cmp_next = cmp_state;
        if (wave_out >= TH_HIGH) begin
            cmp_next = ST_HIGH;
        end else if (wave_out <= TH_LOW) begin
            cmp_next = ST_LOW;
        end
    end

    assign square_wave = (cmp_state == ST_HIGH);

endmodule

// File: tb/tb_hysteresis_wave_comparator.sv
// Bench for hysteresis_wave_comparator: directed scenarios followed by random
// waveform/frequency changes, checked every cycle against a reference model.
module tb_hysteresis_wave_comparator;

    logic       clk_100kHz;
    logic       rst_;
    logic [1:0] sw;
    logic [7:0] freq_ctrl;
    logic [7:0] wave_out;
    logic       square_wave;

    int n_total = 0;
    int n_pass  = 0;

    // reference model state
    int m_phase = 0;
    int m_wave  = 0;
    int m_sq    = 0;

    hysteresis_wave_comparator dut (
        .clk_100kHz  (clk_100kHz),
        .rst_        (rst_),
        .sw          (sw),
        .freq_ctrl   (freq_ctrl),
        .wave_out    (wave_out),
        .square_wave (square_wave)
    );

    initial clk_100kHz = 1'b0;
    always #5 clk_100kHz = ~clk_100kHz;

    function automatic int ref_sample(input int sel, input int p);
        real v;
        int  r;
        case (sel)
            0: begin
                v = 127.0 * $sin(2.0 * 3.14159265358979323846 * p / 256.0);
                r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
                return 128 + r;
            end
            1:       return (p < 128) ? 255 : 0;
            2:       return (p < 128) ? 2 * p : 2 * (255 - p);
            default: return p;
        endcase
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // one clock: model follows the edge, outputs are compared on the falling edge
    task automatic step(input string tag);
        @(posedge clk_100kHz);
        if (rst_) begin
            m_phase = 0;
            m_wave  = 0;
            m_sq    = 0;
        end else begin
            if (m_wave >= 192)     m_sq = 1;
            else if (m_wave <= 64) m_sq = 0;
            m_wave  = ref_sample(int'(sw), m_phase);
            m_phase = (m_phase + int'(freq_ctrl)) % 256;
        end
        @(negedge clk_100kHz);
        check({tag, ".wave"}, int'(wave_out), m_wave);
        check({tag, ".sq"}, int'(square_wave), m_sq);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // reset asserted between edges; outputs must clear without waiting for a clock
    task automatic async_reset(input string tag);
        #2 rst_ = 1'b1;
        #1;
        m_phase = 0;
        m_wave  = 0;
        m_sq    = 0;
        check({tag, ".async_wave"}, int'(wave_out), 0);
        check({tag, ".async_sq"}, int'(square_wave), 0);
        @(negedge clk_100kHz);
        run({tag, ".held"}, 2);
        rst_ = 1'b0;
    endtask

    initial begin
        rst_      = 1'b1;
        sw        = 2'b11;
        freq_ctrl = 8'd1;
        @(negedge clk_100kHz);
        check("reset.wave", int'(wave_out), 0);
        check("reset.sq", int'(square_wave), 0);
        run("reset", 2);
        rst_ = 1'b0;

        // sawtooth ramp through both thresholds and the wrap
        step("saw.first");
        check("saw.first_is_zero", int'(wave_out), 0);
        run("saw", 260);

        // square wave, 50% duty
        sw = 2'b01;
        run("square", 260);

        // sine, full period plus margin
        sw = 2'b00;
        run("sine", 300);

        // fast triangle: hold between thresholds on both slopes
        sw = 2'b10;
        freq_ctrl = 8'd4;
        run("tri", 140);

        // frozen phase, then waveform switches without phase movement
        freq_ctrl = 8'd0;
        run("frozen", 5);
        sw = 2'b11;
        run("frozen.saw", 3);
        sw = 2'b00;
        run("frozen.sine", 3);
        sw = 2'b01;
        run("frozen.sq", 3);

        // reset mid-waveform, restart from phase 0
        sw = 2'b11;
        freq_ctrl = 8'd3;
        run("pre_rst", 70);
        async_reset("midrst");
        step("post_rst");
        check("post_rst.first_is_zero", int'(wave_out), 0);
        run("post_rst", 20);

        // random waveform / increment changes with an occasional reset
        for (int seg = 0; seg < 24; seg++) begin
            sw = 2'($urandom_range(0, 3));
            freq_ctrl = ($urandom_range(0, 3) == 0) ? 8'd1 : 8'($urandom_range(0, 255));
            run("rand", int'($urandom_range(10, 60)));
            if ($urandom_range(0, 7) == 0) async_reset("rand_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
